// File: rtl/vga_tile_reader_if.sv
// Bus between the VGA tile reader and its register bank / display pins.
// master: the reader (drives address and video outputs); slave: bank plus display side.
interface vga_tile_reader_if #(
    parameter int BIT_ADDR = 4,
    parameter int BIT_DATO = 3
);
    logic [BIT_ADDR-1:0] addrR;
    logic [BIT_DATO-1:0] datOutR;
    logic                hsync;
    logic                vsync;
    logic [BIT_DATO-1:0] rgb;
    logic                frame_start;

    modport master (
        output addrR,
        input  datOutR,
        output hsync,
        output vsync,
        output rgb,
        output frame_start
    );

    modport slave (
        input  addrR,
        output datOutR,
        input  hsync,
        input  vsync,
        input  rgb,
        input  frame_start
    );
endinterface

// File: rtl/vga_tile_reader.sv
// VGA timing generator that paints a 4x4 grid of tiles read from a register bank.
// Optional macro TILE_GRID_EN draws black lines on the first pixel row/column of each tile.
module vga_tile_reader #(
    parameter int BIT_ADDR = 4,
    parameter int BIT_DATO = 3,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYN    = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYN    = 2,
    parameter int V_BP     = 33
) (
    input  logic               clk,
    input  logic               rst,
    vga_tile_reader_if.master  bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYN + V_BP;
    localparam int HC_W  = $clog2(H_TOT);
    localparam int VC_W  = $clog2(V_TOT);
    localparam int TW    = H_VIS / 4;
    localparam int TH    = V_VIS / 4;

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOT - 1);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOT - 1);
    localparam logic [HC_W-1:0] H_VISC = HC_W'(H_VIS);
    localparam logic [VC_W-1:0] V_VISC = VC_W'(V_VIS);
    localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0] HS_END = HC_W'(H_VIS + H_FP + H_SYN - 1);
    localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0] VS_END = VC_W'(V_VIS + V_FP + V_SYN - 1);
    localparam logic [HC_W-1:0] TW1 = HC_W'(TW);
    localparam logic [HC_W-1:0] TW2 = HC_W'(2 * TW);
    localparam logic [HC_W-1:0] TW3 = HC_W'(3 * TW);
    localparam logic [VC_W-1:0] TH1 = VC_W'(TH);
    localparam logic [VC_W-1:0] TH2 = VC_W'(2 * TH);
    localparam logic [VC_W-1:0] TH3 = VC_W'(3 * TH);

    logic                phase_q;
    logic                pix_tick;
    logic [HC_W-1:0]     hcnt_q, hcnt_d;
    logic [VC_W-1:0]     vcnt_q, vcnt_d;
    logic [1:0]          col, row;
    logic                visible, hs_raw, vs_raw, grid_raw;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic                vis_p1_q, hs_p1_q, vs_p1_q, grid_p1_q;
    logic [BIT_DATO-1:0] rgb_q, rgb_d;
    logic                hsync_q, vsync_q, fs_q;

    assign pix_tick = phase_q;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Stage p0: decode the current counter position
    always_comb begin
        col      = (hcnt_q >= TW3) ? 2'd3 : (hcnt_q >= TW2) ? 2'd2 : (hcnt_q >= TW1) ? 2'd1 : 2'd0;
        row      = (vcnt_q >= TH3) ? 2'd3 : (vcnt_q >= TH2) ? 2'd2 : (vcnt_q >= TH1) ? 2'd1 : 2'd0;
        visible  = (hcnt_q < H_VISC) && (vcnt_q < V_VISC);
        hs_raw   = !((hcnt_q >= HS_BEG) && (hcnt_q <= HS_END));
        vs_raw   = !((vcnt_q >= VS_BEG) && (vcnt_q <= VS_END));
        addr_d   = visible ? BIT_ADDR'({row, col}) : '0;
`ifdef TILE_GRID_EN
        grid_raw = (hcnt_q == '0) || (hcnt_q == TW1) || (hcnt_q == TW2) || (hcnt_q == TW3) ||
                   (vcnt_q == '0) || (vcnt_q == TH1) || (vcnt_q == TH2) || (vcnt_q == TH3);
`else
        grid_raw = 1'b0;
`endif
    end

    // Stage p1 -> p2: bank data for the registered address becomes the pixel colour
    always_comb begin
        rgb_d = (vis_p1_q && !grid_p1_q) ? bus.datOutR : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            addr_q    <= '0;
            vis_p1_q  <= 1'b0;
            hs_p1_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            grid_p1_q <= 1'b0;
            rgb_q     <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            fs_q    <= pix_tick && (hcnt_q == '0) && (vcnt_q == '0);
            if (pix_tick) begin
                addr_q    <= addr_d;
                vis_p1_q  <= visible;
                hs_p1_q   <= hs_raw;
                vs_p1_q   <= vs_raw;
                grid_p1_q <= grid_raw;
                rgb_q     <= rgb_d;
                hsync_q   <= hs_p1_q;
                vsync_q   <= vs_p1_q;
            end
        end
    end

    assign bus.addrR       = addr_q;
    assign bus.rgb         = rgb_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_tile_reader.sv
// Scoreboard bench for vga_tile_reader on a shrunken raster so several frames fit in a short run.
module tb_vga_tile_reader;
    localparam int H_VIS = 16, H_FP = 2, H_SYN = 3, H_BP = 3;
    localparam int V_VIS = 12, V_FP = 1, V_SYN = 2, V_BP = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYN + V_BP;
    localparam int TW = H_VIS / 4;
    localparam int TH = V_VIS / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    vga_tile_reader_if #(.BIT_ADDR(4), .BIT_DATO(3)) vif ();

    logic [2:0] bank [16];
    assign vif.datOutR = bank[vif.addrR];

    vga_tile_reader #(
        .BIT_ADDR(4), .BIT_DATO(3),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );

    typedef struct {
        int         h;
        int         v;
        int         f;
        logic [3:0] addr;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } pix_t;

    pix_t sb[$];
    int   total = 0, bad = 0;
    int   mh = 0, mv = 0, fr = 0, cyc = 0, last_fs = 0;
    int   hs_lo = 0, vs_lo = 0, nfs = 0, nfs_exp = 0;
    bit   mph = 0, have_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv, $time);
        end
    endtask

    function automatic pix_t model_pix(input int h, input int v);
        pix_t p;
        bit   vis;
        vis    = (h < H_VIS) && (v < V_VIS);
        p.h    = h;
        p.v    = v;
        p.f    = fr;
        p.addr = vis ? 4'((v / TH) * 4 + h / TW) : 4'd0;
        p.rgb  = vis ? bank[p.addr] : 3'd0;
`ifdef TILE_GRID_EN
        if (vis && ((h % TW == 0) || (v % TH == 0))) p.rgb = 3'd0;
`endif
        p.hs   = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYN));
        p.vs   = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYN));
        return p;
    endfunction

    task automatic step();
        bit   tick, exp_fs;
        pix_t p, q;
        @(posedge clk);
        cyc++;
        tick   = 0;
        exp_fs = 0;
        if (rst) begin
            mh = 0; mv = 0; mph = 0; have_prev = 0;
            sb.delete();
        end else begin
            if (mph) begin
                tick   = 1;
                exp_fs = (mh == 0) && (mv == 0);
                if (exp_fs) nfs_exp++;
                p = model_pix(mh, mv);
                sb.push_back(p);
                if (mh == H_TOT - 1) begin
                    mh = 0;
                    if (mv == V_TOT - 1) begin mv = 0; fr++; end
                    else mv++;
                end else begin
                    mh++;
                end
            end
            mph = !mph;
        end
        #1;
        chk("frame_start", vif.frame_start, exp_fs);
        if (vif.frame_start) begin
            nfs++;
            if (have_prev) begin
                chk("frame_period", cyc - last_fs, 2 * H_TOT * V_TOT);
                chk("hsync_low_ticks", hs_lo, H_SYN * V_TOT);
                chk("vsync_low_ticks", vs_lo, V_SYN * H_TOT);
            end
            have_prev = 1;
            last_fs   = cyc;
            hs_lo     = 0;
            vs_lo     = 0;
        end
        if (tick) begin
            chk("addrR", vif.addrR, p.addr);
            if (sb.size() >= 2) begin
                q = sb.pop_front();
                chk("rgb", vif.rgb, q.rgb);
                chk("hsync", vif.hsync, q.hs);
                chk("vsync", vif.vsync, q.vs);
                if (q.h == TW + 2 && q.v == 2 * TH + 1) chk("tile_r2c1", vif.rgb, 3'b001);
                if (q.h == H_VIS + 2 && q.v == 5) chk("hblank_rgb", vif.rgb, 3'b000);
                if (q.h == 5 && q.v == V_VIS + 2) chk("vblank_rgb", vif.rgb, 3'b000);
                if (q.h == 3 * TW + 1 && q.v == 3 * TH + 1)
                    chk("cell15", vif.rgb, (q.f == 0) ? 3'b010 : 3'b101);
`ifdef TILE_GRID_EN
                if (q.h == TW && q.v == 1) chk("grid_line", vif.rgb, 3'b000);
                if (q.h == TW + 1 && q.v == 1) chk("grid_next", vif.rgb, 3'b001);
`endif
            end
            if (!vif.hsync) hs_lo++;
            if (!vif.vsync) vs_lo++;
        end
    endtask

    initial begin
        bit reached;
        for (int k = 0; k < 16; k++) bank[k] = 3'(k % 8);
        bank[0]  = 3'b111;
        bank[15] = 3'b010;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_addrR", vif.addrR, 0);
        chk("rst_rgb", vif.rgb, 0);
        chk("rst_hsync", vif.hsync, 1);
        chk("rst_vsync", vif.vsync, 1);
        rst = 1'b0;

        reached = 0;
        for (int n = 0; n < 5000 && !reached; n++) begin
            step();
            if (fr == 1 && mv == 1 && mh == 0) bank[15] = 3'b101;
            if (fr == 2 && mv == 2 * TH + 1 && mh == 3) reached = 1;
        end
        chk("reach_midframe", reached, 1);

        rst = 1'b1;
        #5;
        chk("midrst_addrR", vif.addrR, 0);
        chk("midrst_rgb", vif.rgb, 0);
        chk("midrst_hsync", vif.hsync, 1);
        chk("midrst_vsync", vif.vsync, 1);
        chk("midrst_fs", vif.frame_start, 0);
        repeat (4) step();
        rst = 1'b0;
        step();
        chk("fs_after_rst_early", vif.frame_start, 0);
        step();
        chk("fs_after_rst_first_tick", vif.frame_start, 1);
        repeat (2 * H_TOT * V_TOT + 8 * H_TOT) step();
        chk("fs_count", nfs, nfs_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
